// File: rtl/conv_window_gen_pkg.sv
// Shared constants and helpers for the 5x5 convolution window datapath.
// The MAC datapath uses the same window element indexing.
package conv_pkg;
   localparam int DATA_W    = 32;
   localparam int KERNEL    = 5;
   localparam int WIN_ELEMS = KERNEL * KERNEL;

   function automatic int win_idx(input int r, input int c);
      return r * KERNEL + c;
   endfunction

   // Counter width that never collapses to zero bits.
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/conv_window_gen_if.sv
// Pixel-in / window-out handshake bundle of the window generator.
interface conv_window_gen_if #(
   parameter int DATA_W = conv_pkg::DATA_W,
   parameter int ROW_W  = 1,
   parameter int COL_W  = 1
);
   logic                                    pix_valid;
   logic [DATA_W-1:0]                       pix_data;
   logic                                    pix_ready;
   logic                                    win_valid;
   logic [conv_pkg::WIN_ELEMS*DATA_W-1:0]   win_data;
   logic                                    win_ready;
   logic [ROW_W-1:0]                        win_row;
   logic [COL_W-1:0]                        win_col;
   logic                                    frame_done;

   modport slave (
      input  pix_valid, pix_data, win_ready,
      output pix_ready, win_valid, win_data, win_row, win_col, frame_done
   );

   modport master (
      output pix_valid, pix_data, win_ready,
      input  pix_ready, win_valid, win_data, win_row, win_col, frame_done
   );
endinterface

// File: rtl/conv_window_gen_line_buffer.sv
// One image row of delay: the word at a column address is read out before
// the incoming word of the next row overwrites it.
module conv_line_buffer #(
   parameter int DEPTH  = 28,
   parameter int DATA_W = 32,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic [AW-1:0]     addr_i,
   input  logic [DATA_W-1:0] din_i,
   output logic [DATA_W-1:0] dout_o
);
   logic [DATA_W-1:0] mem_q [DEPTH];

   assign dout_o = mem_q[addr_i];

   always_ff @(posedge clk) begin
      if (we_i) mem_q[addr_i] <= din_i;
   end
endmodule

// File: rtl/conv_window_gen.sv
// Sliding 5x5 window generator over a raster pixel stream, one window per
// accepted pixel once the kernel fits inside the current row.
module conv_window_gen #(
   parameter int IMG_W  = 28,
   parameter int IMG_H  = 28,
   parameter int DATA_W = conv_pkg::DATA_W
) (
   input  logic             clk,
   input  logic             rst_n,
   conv_window_gen_if.slave bus
);
   import conv_pkg::*;

   localparam int IN_CW  = cnt_w(IMG_W);
   localparam int IN_RW  = cnt_w(IMG_H);
   localparam int OUT_CW = cnt_w(IMG_W - 4);
   localparam int OUT_RW = cnt_w(IMG_H - 4);
   localparam int LB_N   = KERNEL - 1;

   logic [IN_CW-1:0]  in_col_q, in_col_d;
   logic [IN_RW-1:0]  in_row_q, in_row_d;
   logic [OUT_CW-1:0] win_col_q, win_col_d;
   logic [OUT_RW-1:0] win_row_q, win_row_d;
   logic              win_valid_q, win_valid_d;
   logic              frame_done_q, frame_done_d;
   logic              pix_xfer, win_xfer, produce, last_col, last_row;

   logic [DATA_W-1:0] win_q   [KERNEL][KERNEL];
   logic [DATA_W-1:0] lb_din  [LB_N];
   logic [DATA_W-1:0] lb_dout [LB_N];
   logic [DATA_W-1:0] col_new [KERNEL];

   assign bus.pix_ready = !win_valid_q || bus.win_ready;
   assign pix_xfer      = bus.pix_valid && bus.pix_ready;
   assign win_xfer      = win_valid_q && bus.win_ready;

   // Line buffers are chained: buffer i delays by i+1 rows.
   always_comb begin
      lb_din[0] = bus.pix_data;
      for (int i = 1; i < LB_N; i++) lb_din[i] = lb_dout[i-1];
      col_new[KERNEL-1] = bus.pix_data;
      for (int r = 0; r < LB_N; r++) col_new[r] = lb_dout[LB_N-1-r];
   end

   for (genvar i = 0; i < LB_N; i++) begin : g_lb
      conv_line_buffer #(.DEPTH(IMG_W), .DATA_W(DATA_W)) u_lb (
         .clk    (clk),
         .we_i   (pix_xfer),
         .addr_i (in_col_q),
         .din_i  (lb_din[i]),
         .dout_o (lb_dout[i])
      );
   end

   always_comb begin
      produce      = (in_row_q >= IN_RW'(KERNEL-1)) && (in_col_q >= IN_CW'(KERNEL-1));
      last_col     = in_col_q == IN_CW'(IMG_W-1);
      last_row     = in_row_q == IN_RW'(IMG_H-1);
      in_col_d     = in_col_q;
      in_row_d     = in_row_q;
      win_valid_d  = win_valid_q;
      frame_done_d = frame_done_q;
      win_row_d    = win_row_q;
      win_col_d    = win_col_q;
      if (pix_xfer) begin
         in_col_d     = last_col ? '0 : in_col_q + 1'b1;
         if (last_col) in_row_d = last_row ? '0 : in_row_q + 1'b1;
         win_valid_d  = produce;
         frame_done_d = produce && last_col && last_row;
         if (produce) begin
            win_row_d = OUT_RW'(in_row_q - IN_RW'(KERNEL-1));
            win_col_d = OUT_CW'(in_col_q - IN_CW'(KERNEL-1));
         end
      end else if (win_xfer) begin
         win_valid_d  = 1'b0;
         frame_done_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         in_col_q     <= '0;
         in_row_q     <= '0;
         win_col_q    <= '0;
         win_row_q    <= '0;
         win_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
         for (int r = 0; r < KERNEL; r++)
            for (int c = 0; c < KERNEL; c++) win_q[r][c] <= '0;
      end else begin
         in_col_q     <= in_col_d;
         in_row_q     <= in_row_d;
         win_col_q    <= win_col_d;
         win_row_q    <= win_row_d;
         win_valid_q  <= win_valid_d;
         frame_done_q <= frame_done_d;
         // Window only moves on an accepted pixel, so a stalled window holds.
         if (pix_xfer) begin
            for (int r = 0; r < KERNEL; r++) begin
               for (int c = 0; c < KERNEL-1; c++) win_q[r][c] <= win_q[r][c+1];
               win_q[r][KERNEL-1] <= col_new[r];
            end
         end
      end
   end

   always_comb begin
      bus.win_data = '0;
      for (int r = 0; r < KERNEL; r++)
         for (int c = 0; c < KERNEL; c++)
            bus.win_data[win_idx(r, c)*DATA_W +: DATA_W] = win_q[r][c];
   end

   assign bus.win_valid  = win_valid_q;
   assign bus.win_row    = win_row_q;
   assign bus.win_col    = win_col_q;
   assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen on a 6x6 image with pixel value r*6+c.
module tb_conv_window_gen;
   localparam int IMG_W    = 6;
   localparam int IMG_H    = 6;
   localparam int DATA_W   = 32;
   localparam int RW       = conv_pkg::cnt_w(IMG_H - 4);
   localparam int CW       = conv_pkg::cnt_w(IMG_W - 4);
   localparam int WIN_BITS = 25 * DATA_W;
   localparam int NPIX     = IMG_W * IMG_H;

   typedef struct {
      int row;
      int col;
      int e0;
      int e24;
      bit fd;
   } exp_t;

   typedef struct {
      int                  row;
      int                  col;
      int                  e0;
      int                  e24;
      bit                  fd;
      logic [WIN_BITS-1:0] data;
      int                  pix_at;
      int                  cyc;
   } cap_t;

   logic clk = 1'b0;
   logic rst_n;
   int   assertions = 0;
   int   fails = 0;
   int   pix_idx = 0;
   int   cyc = 0;
   exp_t exp_tab[4];
   cap_t caps[$];

   conv_window_gen_if #(.DATA_W(DATA_W), .ROW_W(RW), .COL_W(CW)) bus ();

   conv_window_gen #(.IMG_W(IMG_W), .IMG_H(IMG_H), .DATA_W(DATA_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_int(input string name, input int act, input int exp);
      assertions++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Called at posedge+1: drives one cycle, records transfers, ends at next posedge+1.
   task automatic step(input logic pv, input logic wr);
      cap_t c;
      bus.pix_valid = pv;
      bus.pix_data  = DATA_W'(pix_idx % NPIX);
      bus.win_ready = wr;
      #1;
      if (bus.win_valid && wr) begin
         c.row    = int'(bus.win_row);
         c.col    = int'(bus.win_col);
         c.e0     = int'(bus.win_data[0 +: DATA_W]);
         c.e24    = int'(bus.win_data[24*DATA_W +: DATA_W]);
         c.fd     = bus.frame_done;
         c.data   = bus.win_data;
         c.pix_at = pix_idx;
         c.cyc    = cyc;
         caps.push_back(c);
      end
      if (pv && bus.pix_ready) pix_idx++;
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input bit check);
      bus.pix_valid = 1'b0;
      bus.win_ready = 1'b0;
      bus.pix_data  = '0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      if (check) begin
         check_int("rst win_valid", int'(bus.win_valid), 0);
         check_int("rst frame_done", int'(bus.frame_done), 0);
         check_int("rst win_row", int'(bus.win_row), 0);
         check_int("rst win_col", int'(bus.win_col), 0);
         check_int("rst win_data zero", int'(bus.win_data == '0), 1);
      end
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_int("post-reset pix_ready", int'(bus.pix_ready), 1);
      pix_idx = 0;
      caps.delete();
   endtask

   task automatic run_pixels(input int npix, input bit gaps);
      int budget = 0;
      while (pix_idx < npix && budget < 2000) begin
         step(gaps ? 1'($urandom_range(0, 1)) : 1'b1, 1'b1);
         budget++;
      end
      if (pix_idx < npix) begin
         assertions++;
         fails++;
         $display("FAIL pixel budget: accepted %0d, required %0d", pix_idx, npix);
      end
      repeat (3) step(1'b0, 1'b1);
   endtask

   task automatic check_windows(input string tag, input int nwin);
      int fd_cnt = 0;
      check_int({tag, " window count"}, caps.size(), nwin);
      if (caps.size() > 0) check_int({tag, " first window pixel count"}, caps[0].pix_at, 29);
      for (int i = 0; i < caps.size() && i < nwin; i++) begin
         exp_t e = exp_tab[i % 4];
         int bad = 0;
         for (int k = 0; k < 25; k++) begin
            int ev = (e.row + k / 5) * IMG_W + e.col + k % 5;
            if (caps[i].data[k*DATA_W +: DATA_W] !== DATA_W'(ev)) bad++;
         end
         check_int($sformatf("%s w%0d row", tag, i), caps[i].row, e.row);
         check_int($sformatf("%s w%0d col", tag, i), caps[i].col, e.col);
         check_int($sformatf("%s w%0d elem0", tag, i), caps[i].e0, e.e0);
         check_int($sformatf("%s w%0d elem24", tag, i), caps[i].e24, e.e24);
         check_int($sformatf("%s w%0d frame_done", tag, i), int'(caps[i].fd), int'(e.fd));
         check_int($sformatf("%s w%0d bad elems", tag, i), bad, 0);
         if (caps[i].fd) fd_cnt++;
      end
      check_int({tag, " frame_done pulses"}, fd_cnt, nwin / 4);
   endtask

   initial begin
      bit stalled;
      int budget;

      exp_tab[0] = '{row: 0, col: 0, e0: 0, e24: 28, fd: 1'b0};
      exp_tab[1] = '{row: 0, col: 1, e0: 1, e24: 29, fd: 1'b0};
      exp_tab[2] = '{row: 1, col: 0, e0: 6, e24: 34, fd: 1'b0};
      exp_tab[3] = '{row: 1, col: 1, e0: 7, e24: 35, fd: 1'b1};

      rst_n = 1'b0;
      bus.pix_valid = 1'b0;
      bus.pix_data  = '0;
      bus.win_ready = 1'b0;
      @(posedge clk);
      #1;

      // Continuous streaming, one frame.
      do_reset(1'b1);
      run_pixels(NPIX, 1'b0);
      check_windows("stream", 4);
      if (caps.size() >= 2) check_int("back-to-back window cycles", caps[1].cyc - caps[0].cyc, 1);

      // Downstream stall on window (0,1).
      do_reset(1'b0);
      stalled = 1'b0;
      budget = 0;
      while (pix_idx < NPIX && budget < 2000) begin
         if (!stalled && bus.win_valid && bus.win_row == 0 && bus.win_col == 1) begin
            stalled = 1'b1;
            for (int s = 0; s < 5; s++) begin
               step(1'b1, 1'b0);
               check_int("stall pix_ready", int'(bus.pix_ready), 0);
               check_int("stall elem0", int'(bus.win_data[0 +: DATA_W]), 1);
               check_int("stall win_col", int'(bus.win_col), 1);
            end
         end else begin
            step(1'b1, 1'b1);
         end
         budget++;
      end
      repeat (3) step(1'b0, 1'b1);
      check_int("stall reached", int'(stalled), 1);
      check_windows("stall", 4);

      // Random input gaps.
      do_reset(1'b0);
      run_pixels(NPIX, 1'b1);
      check_windows("gaps", 4);

      // Two frames back-to-back.
      do_reset(1'b0);
      run_pixels(2 * NPIX, 1'b0);
      check_windows("two frames", 8);

      // Reset in the middle of a frame.
      do_reset(1'b0);
      run_pixels(20, 1'b0);
      check_int("partial frame windows", caps.size(), 0);
      do_reset(1'b1);
      run_pixels(NPIX, 1'b0);
      check_windows("after reset", 4);

      $display("End of test - %0d assertions evaluated, %0d failures", assertions, fails);
      $finish;
   end
endmodule
